// File: rtl/mips_muldiv_pkg.sv
// ---------------------------------------------------------------------------
// mips_muldiv_pkg
// Shared definitions for the HI/LO multiply/divide unit. The decoder uses the
// same function-code constants.
//   FUNCT_MULT/MULTU/DIV/DIVU : R-type function codes 0x18..0x1B
//   muldiv_state_t            : IDLE / RUN / FIX sequencing states
//   is_muldiv_funct()         : true for the four codes that launch an op
// ---------------------------------------------------------------------------
package mips_muldiv_pkg;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    function automatic logic is_muldiv_funct(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    endfunction

endpackage

// File: rtl/hi_lo_multiply_divide_unit.sv
// ---------------------------------------------------------------------------
// hi_lo_multiply_divide_unit
// Iterative 32-bit multiply/divide with the architectural HI/LO registers.
// One result bit per cycle: 32 RUN cycles plus one FIX cycle that applies
// the sign corrections and writes HI/LO.
// Ports:
//   clk, reset                 rising-edge clock, async active-high reset
//   start                      launch request (MULT/MULTU/DIV/DIVU only)
//   ALU_function_execute       function code
//   src_A_execute/src_B_execute multiplicand/dividend, multiplier/divisor
//   HI/LO_register_write_execute, HI_LO_write_data   MTHI/MTLO port
//   busy                       operation in progress (registered)
//   done                       one-cycle pulse when HI/LO get a result
//   HI, LO                     architectural registers
// ---------------------------------------------------------------------------
module hi_lo_multiply_divide_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       ALU_function_execute,
    input  logic [WIDTH-1:0] src_A_execute,
    input  logic [WIDTH-1:0] src_B_execute,
    input  logic             HI_register_write_execute,
    input  logic             LO_register_write_execute,
    input  logic [WIDTH-1:0] HI_LO_write_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    muldiv_state_t      state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;     // product, or {remainder, quotient}
    logic [WIDTH-1:0]   a_q, a_d;         // |A|; shifts left during divide
    logic [WIDTH-1:0]   b_q, b_d;         // |B|; shifts right during multiply
    logic [WIDTH-1:0]   raw_a_q, raw_a_d; // unmodified A for divide-by-zero HI
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d; // negate product / quotient
    logic               neg_rem_q, neg_rem_d; // negate remainder (DIV only)

    // Per-step datapath
    logic               accept;
    logic               is_signed_op;
    logic               sign_a, sign_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_sub;
    logic               div_borrow;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod_fixed;

    assign accept       = (state_q == IDLE) && start && is_muldiv_funct(ALU_function_execute);
    assign is_signed_op = (ALU_function_execute == FUNCT_MULT) ||
                          (ALU_function_execute == FUNCT_DIV);
    assign sign_a       = is_signed_op && src_A_execute[WIDTH-1];
    assign sign_b       = is_signed_op && src_B_execute[WIDTH-1];

    // Shift-add: add |A| into the upper half when the current multiplier bit
    // is set, then shift the whole 65-bit sum right by one.
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};

    // Restoring divide: bring in the next dividend bit and trial-subtract.
    // The extra top bit of div_sub is the borrow (trial went negative).
    assign div_shift  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign div_sub    = {1'b0, div_shift} - {2'b00, b_q};
    assign div_borrow = div_sub[WIDTH+1];
    assign rem_next   = div_borrow ? div_shift[WIDTH-1:0] : div_sub[WIDTH-1:0];

    assign prod_fixed = neg_res_q ? -acc_q : acc_q;

    // NOTE: every signal written below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        acc_d     = acc_q;
        a_d       = a_q;
        b_d       = b_q;
        raw_a_d   = raw_a_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // A launch takes priority over a same-cycle MTHI/MTLO.
                    a_d       = sign_a ? -src_A_execute : src_A_execute;
                    b_d       = sign_b ? -src_B_execute : src_B_execute;
                    raw_a_d   = src_A_execute;
                    is_div_d  = (ALU_function_execute == FUNCT_DIV) ||
                                (ALU_function_execute == FUNCT_DIVU);
                    neg_res_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    acc_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = RUN;
                end else begin
                    if (HI_register_write_execute) hi_d = HI_LO_write_data;
                    if (LO_register_write_execute) lo_d = HI_LO_write_data;
                end
            end
            RUN: begin
                if (is_div_q) begin
                    acc_d = {rem_next, acc_q[WIDTH-2:0], ~div_borrow};
                    a_d   = a_q << 1;
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    b_d   = b_q >> 1;
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) state_d = FIX;
            end
            FIX: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fixed;
                end else if (b_q == '0) begin
                    lo_d = '1;
                    hi_d = raw_a_q;
                end else begin
                    lo_d = neg_res_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            raw_a_q   <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            raw_a_q   <= raw_a_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_hi_lo_multiply_divide_unit.sv
// ---------------------------------------------------------------------------
// tb_hi_lo_multiply_divide_unit
// Directed vectors with hand-computed HI/LO results, plus hand-written
// sequences for reset during an operation, ignored requests while busy,
// MTHI/MTLO writes, start-vs-MT priority and unsupported function codes.
// ---------------------------------------------------------------------------
module tb_hi_lo_multiply_divide_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'h00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    hi_lo_multiply_divide_unit #(.WIDTH(32)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .start                     (start),
        .ALU_function_execute      (funct),
        .src_A_execute             (src_a),
        .src_B_execute             (src_b),
        .HI_register_write_execute (hi_we),
        .LO_register_write_execute (lo_we),
        .HI_LO_write_data          (wdata),
        .busy                      (busy),
        .done                      (done),
        .HI                        (hi),
        .LO                        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a launch for one cycle; returns at the falling edge after E0.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct = f;
        src_a = a;
        src_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count remaining busy cycles (bounded), then check the done pulse and result.
    task automatic wait_done(input string name, input int exp_busy,
                             input logic [31:0] eh, input logic [31:0] el);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, " busy cycles"}, 64'(n), 64'(exp_busy));
        check({name, " done pulse"}, 64'(done), 64'd1);
        check({name, " HI"}, 64'(hi), 64'(eh));
        check({name, " LO"}, 64'(lo), 64'(el));
        @(negedge clk);
        check({name, " done drop"}, 64'(done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"multu_max",   6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_m3x7",   6'h18, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"div_m7d2",    6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_7d0",    6'h1B, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[4]  = '{"div_min_m1",  6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"multu_3x5",   6'h19, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
        vecs[6]  = '{"div_7dm2",    6'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{"div_m7d0",    6'h1A, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[8]  = '{"divu_100d7",  6'h1B, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[9]  = '{"mult_min2",   6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[10] = '{"divu_max_d1", 6'h1B, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
        vecs[11] = '{"mult_m1x1",   6'h18, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};

        // Reset state
        #12;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset HI", 64'(hi), 64'd0);
        check("reset LO", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors: 33 busy cycles, one-cycle done, correct HI/LO
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].funct, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].name, 33, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Reset with the counter at 10 discards the operation at once
        issue(6'h19, 32'hFFFFFFFF, 32'h00000002);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrun reset busy", 64'(busy), 64'd0);
        check("midrun reset done", 64'(done), 64'd0);
        check("midrun reset HI", 64'(hi), 64'd0);
        check("midrun reset LO", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(6'h19, 32'd3, 32'd5);
        wait_done("after_reset_3x5", 33, 32'h0, 32'd15);

        // While busy: DIVU start and MTHI/MTLO are ignored, HI/LO hold old value
        issue(6'h18, 32'hFFFFFFFD, 32'h00000007);
        check("run holds HI", 64'(hi), 64'h0);
        check("run holds LO", 64'(lo), 64'd15);
        repeat (5) @(negedge clk);
        start = 1'b1;
        funct = 6'h1B;
        src_a = 32'd100;
        src_b = 32'd7;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h12345678;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("busy ignores MT HI", 64'(hi), 64'h0);
        wait_done("busy_ignore", 27, 32'hFFFFFFFF, 32'hFFFFFFEB);
        check("no second op", 64'(busy), 64'd0);

        // MTHI in IDLE: one-edge latency, LO untouched
        hi_we = 1'b1;
        wdata = 32'h12345678;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi HI", 64'(hi), 64'h12345678);
        check("mthi LO kept", 64'(lo), 64'hFFFFFFEB);

        // MTHI and MTLO together
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hCAFEF00D;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mt both HI", 64'(hi), 64'hCAFEF00D);
        check("mt both LO", 64'(lo), 64'hCAFEF00D);

        // Start and MT in the same cycle: the write is dropped
        @(negedge clk);
        funct = 6'h19;
        src_a = 32'd6;
        src_b = 32'd7;
        start = 1'b1;
        hi_we = 1'b1;
        wdata = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        check("start wins busy", 64'(busy), 64'd1);
        check("start wins HI", 64'(hi), 64'hCAFEF00D);
        wait_done("start_wins", 33, 32'h0, 32'd42);

        // Unsupported function code does not launch
        @(negedge clk);
        funct = 6'h20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("bad funct busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("bad funct done", 64'(done), 64'd0);
        check("bad funct LO", 64'(lo), 64'd42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hi_lo_multiply_divide_unit.md
# hi_lo_multiply_divide_unit

Iterative multiply/divide unit with the architectural HI/LO registers. Sits in the execute stage directly downstream of the decode/execute pipeline register. Consumes the execute-side operands and function code for MULT/MULTU/DIV/DIVU and writes MTHI/MTLO data. Exposes `busy` so the hazard unit can stall HI/LO readers and back-to-back mult/div instructions.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  launch request for the operation in `ALU_function_execute`
- `ALU_function_execute`  in  6  function code: 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU
- `src_A_execute`  in  32  multiplicand / dividend
- `src_B_execute`  in  32  multiplier / divisor
- `HI_register_write_execute`  in  1  MTHI write enable
- `LO_register_write_execute`  in  1  MTLO write enable
- `HI_LO_write_data`  in  32  MTHI/MTLO data
- `busy`  out  1  operation in progress (registered)
- `done`  out  1  one-cycle pulse: HI/LO were just updated by mult/div
- `HI`  out  32  HI register
- `LO`  out  32  LO register

## Operation
- States: IDLE, RUN, FIX. Reset forces IDLE, `busy`=0, `done`=0, `HI`=`LO`=0, step counter 0.
- IDLE, `start`=1 with funct 0x18–0x1B:
  - Latch the operand magnitudes (signed ops only), result-sign flags and op type.
  - Clear the 64-bit accumulator; counter=0; go to RUN.
- `start` with any other funct is ignored.
- RUN, multiply: shift-add, one multiplier bit per cycle into a 64-bit product.
- RUN, divide: restoring division, one quotient bit per cycle, 33-bit partial remainder.
- Counter 0..31. After the step with counter=31, go to FIX.
- FIX writes results, pulses `done`, and returns to IDLE:
  - Multiply: {HI,LO} = product. Negate as 64-bit if signA^signB (MULT only).
  - Divide: LO = quotient, negated if signA^signB; HI = remainder, negated if signA (DIV only).
- Divide by zero (DIV or DIVU): LO=0xFFFFFFFF, HI=src_A as latched (raw, no sign fix).
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural magnitude-path result.
- MTHI/MTLO: in IDLE only, `HI`/`LO` take `HI_LO_write_data` on the next edge. Both may be written in the same cycle.
- While `busy`=1, `start` and MTHI/MTLO writes are ignored. The hazard unit guarantees stalls.
- `start` and an MT write in the same IDLE cycle: `start` wins and the write is dropped.

## Timing
- Accept edge E0 (IDLE, `start`=1, valid funct). `busy`=1 from after E0.
- RUN occupies edges E0+1 .. E0+32. FIX edge is E0+33.
- After E0+33: `HI`/`LO` hold the result, `done`=1 for one cycle, `busy`=0.
- A new `start` can be accepted at edge E0+34: 34-cycle issue interval.
- `HI`/`LO` keep their old values throughout RUN. There is no partial-result visibility.
- Reset asserted mid-RUN/FIX takes effect immediately (asynchronous). The operation is discarded and all outputs return to reset values.
- MT write latency is 1 edge. `HI`/`LO` are registered outputs with no combinational path from inputs.

## Structure
- Shared package `mips_muldiv_pkg` holds:
  - funct constants FUNCT_MULT/MULTU/DIV/DIVU (0x18–0x1B), also used by the decoder;
  - state enum `muldiv_state_t` {IDLE, RUN, FIX}.
- Single module. No sub-module: the datapath (64-bit accumulator, 33-bit subtractor, sign fix) is small enough to keep flat.

## Test plan
- MULTU 0xFFFFFFFF×0xFFFFFFFF. Expect:
  - HI=0xFFFFFFFE, LO=0x00000001 after edge E0+33;
  - `busy` high exactly 33 cycles;
  - `done` high one cycle.
- MULT 0xFFFFFFFD(−3)×7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=0x00000007.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0x00000000.
- Start MULTU, assert `reset` at RUN counter=10. Expect:
  - immediately `busy`=0, HI=LO=0;
  - next MULTU 3×5 gives LO=15, HI=0.
- While busy: `start` (DIVU) and MTHI 0x12345678 are ignored and the original result lands. Then in IDLE, MTHI 0x12345678 → HI=0x12345678 after one edge, LO unchanged.
